// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle for the operand sequencer: switches/buttons in, ALU operand/result buses.
// master = sequencer (drives ALU inputs, latches results); slave = board + ALU side.
// No handshake: all signals are level, sampled every core cycle.
interface alu_operand_sequencer_if;
    logic [15:0] sw_data;
    logic [1:0]  key_n;
    logic [31:0] alu_porta;
    logic [31:0] alu_portb;
    logic [3:0]  alu_op;
    logic [31:0] alu_outport;
    logic        alu_negf;
    logic        alu_zerf;
    logic        alu_ovef;
    logic [31:0] result;
    logic [2:0]  flags;
    logic        result_valid;
    logic [2:0]  state_o;
    logic [31:0] disp_value;

    modport master (
        input  sw_data, key_n, alu_outport, alu_negf, alu_zerf, alu_ovef,
        output alu_porta, alu_portb, alu_op, result, flags, result_valid, state_o, disp_value
    );

    modport slave (
        output sw_data, key_n, alu_outport, alu_negf, alu_zerf, alu_ovef,
        input  alu_porta, alu_portb, alu_op, result, flags, result_valid, state_o, disp_value
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Debounced button-driven loader for ALU operands/opcode, with result/flag capture for display.
// Latency: press pulse DEBOUNCE_CYCLES+3 after a clean edge; result ALU_WAIT+1 cycles after op enter.
// No backpressure: buttons are level inputs, the ALU is combinational and never stalls.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_WAIT        = 1
) (
    input logic                    CLK,
    input logic                    nRST,
    alu_operand_sequencer_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int WW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_WAIT - 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    logic [1:0]    sync1, sync2, stable, press;
    logic [CW-1:0] cnt [2];

    // Buttons idle high; a press is a debounced 1->0 of the stable level.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            stable <= 2'b11;
            press  <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                    press[k]  <= ~sync2[k];
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    logic        enter, clr;
    logic [31:0] sext;
    assign enter = press[0];
    assign clr   = press[1];
    assign sext  = {{16{bus.sw_data[15]}}, bus.sw_data};

    state_t      state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [31:0] porta, porta_nx, portb, portb_nx, result, result_nx;
    logic [3:0]  op, op_nx;
    logic [2:0]  flags, flags_nx;
    logic        rv, rv_nx;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= LOAD_A;
            wait_cnt <= '0;
            porta    <= '0;
            portb    <= '0;
            op       <= '0;
            result   <= '0;
            flags    <= '0;
            rv       <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            porta    <= porta_nx;
            portb    <= portb_nx;
            op       <= op_nx;
            result   <= result_nx;
            flags    <= flags_nx;
            rv       <= rv_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wait_nx   = wait_cnt;
        porta_nx  = porta;
        portb_nx  = portb;
        op_nx     = op;
        result_nx = result;
        flags_nx  = flags;
        rv_nx     = rv;
        // Clear outranks a same-cycle enter.
        if (clr) begin
            state_nx  = LOAD_A;
            wait_nx   = '0;
            porta_nx  = '0;
            portb_nx  = '0;
            op_nx     = '0;
            result_nx = '0;
            flags_nx  = '0;
            rv_nx     = 1'b0;
        end else begin
            case (state)
                LOAD_A: if (enter) begin
                    porta_nx = sext;
                    rv_nx    = 1'b0;
                    state_nx = LOAD_B;
                end
                LOAD_B: if (enter) begin
                    portb_nx = sext;
                    state_nx = LOAD_OP;
                end
                LOAD_OP: if (enter) begin
                    op_nx    = bus.sw_data[3:0];
                    wait_nx  = '0;
                    state_nx = EXEC;
                end
                EXEC: begin
                    if (wait_cnt == WAIT_LAST) begin
                        result_nx = bus.alu_outport;
                        flags_nx  = {bus.alu_negf, bus.alu_zerf, bus.alu_ovef};
                        rv_nx     = 1'b1;
                        wait_nx   = '0;
                        state_nx  = SHOW;
                    end else begin
                        wait_nx = wait_cnt + 1'b1;
                    end
                end
                SHOW: if (enter) state_nx = LOAD_A;
                default: state_nx = LOAD_A;
            endcase
        end
    end

    always_comb begin
        bus.disp_value = result;
        case (state)
            LOAD_A, LOAD_B: bus.disp_value = sext;
            LOAD_OP:        bus.disp_value = {28'b0, bus.sw_data[3:0]};
            EXEC:           bus.disp_value = bus.alu_outport;
            default:        bus.disp_value = result;
        endcase
    end

    assign bus.alu_porta    = porta;
    assign bus.alu_portb    = portb;
    assign bus.alu_op       = op;
    assign bus.result       = result;
    assign bus.flags        = flags;
    assign bus.result_valid = rv;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (ALU_WAIT=1 and 3) share switch/button stimulus;
// each sees an adder ALU model. Expected results are queued at op entry and popped at capture.
module tb_alu_operand_sequencer;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] sw_data = 16'h0000;
    logic [1:0]  key_n = 2'b11;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [34:0] exp_q[$];

    alu_operand_sequencer_if ifa();
    alu_operand_sequencer_if ifb();

    logic [31:0] suma, sumb;
    assign suma = ifa.alu_porta + ifa.alu_portb;
    assign sumb = ifb.alu_porta + ifb.alu_portb;

    assign ifa.sw_data     = sw_data;
    assign ifa.key_n       = key_n;
    assign ifa.alu_outport = suma;
    assign ifa.alu_negf    = suma[31];
    assign ifa.alu_zerf    = (suma == 32'd0);
    assign ifa.alu_ovef    = (ifa.alu_porta[31] == ifa.alu_portb[31]) && (suma[31] != ifa.alu_porta[31]);
    assign ifb.sw_data     = sw_data;
    assign ifb.key_n       = key_n;
    assign ifb.alu_outport = sumb;
    assign ifb.alu_negf    = sumb[31];
    assign ifb.alu_zerf    = (sumb == 32'd0);
    assign ifb.alu_ovef    = (ifb.alu_porta[31] == ifb.alu_portb[31]) && (sumb[31] != ifb.alu_porta[31]);

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_WAIT(1)) dut_a (.CLK(CLK), .nRST(nRST), .bus(ifa.master));
    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_WAIT(3)) dut_b (.CLK(CLK), .nRST(nRST), .bus(ifb.master));

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        tick(8);
        key_n[k] = 1'b1;
        tick(8);
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
        @(negedge CLK);
        n_cmp++; if (ifa.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", ifa.state_o); end
        n_cmp++; if ({ifa.alu_porta, ifa.alu_portb, ifa.alu_op} !== 68'd0) begin n_bad++; $display("FAIL reset_operands: got %h %h %h want 0", ifa.alu_porta, ifa.alu_portb, ifa.alu_op); end
        n_cmp++; if ({ifa.result, ifa.flags, ifa.result_valid} !== 36'd0) begin n_bad++; $display("FAIL reset_result: got %h %b %b want 0", ifa.result, ifa.flags, ifa.result_valid); end
        n_cmp++; if (ifb.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state_b: got %0d want 0", ifb.state_o); end
    endtask

    task automatic test_sign_ext;
        logic [15:0] sw_v [2];
        logic [31:0] ext_v [2];
        sw_v[0] = 16'h8000; ext_v[0] = 32'hFFFF8000;
        sw_v[1] = 16'h7FFF; ext_v[1] = 32'h00007FFF;
        for (int i = 0; i < 2; i++) begin
            sw_data = sw_v[i];
            @(negedge CLK);
            n_cmp++; if (ifa.disp_value !== ext_v[i]) begin n_bad++; $display("FAIL sext_disp: got %h want %h", ifa.disp_value, ext_v[i]); end
            press(0);
            @(negedge CLK);
            n_cmp++; if (ifa.alu_porta !== ext_v[i]) begin n_bad++; $display("FAIL sext_porta: got %h want %h", ifa.alu_porta, ext_v[i]); end
            n_cmp++; if (ifa.state_o !== 3'd1) begin n_bad++; $display("FAIL sext_state: got %0d want 1", ifa.state_o); end
            press(1);
            @(negedge CLK);
            n_cmp++; if ({ifa.state_o, ifa.alu_porta} !== 35'd0) begin n_bad++; $display("FAIL clear_after_a: got %0d %h want 0 0", ifa.state_o, ifa.alu_porta); end
        end
    endtask

    task automatic test_bounce;
        int          trans = 0;
        int          other = 0;
        logic [2:0]  prev;
        prev = ifa.state_o;
        for (int i = 0; i < 32; i++) begin
            if (i < 12 && (i % 2) == 0) key_n[0] = ~key_n[0];
            if (i == 12) key_n[0] = 1'b0;
            if (i == 22) key_n[0] = 1'b1;
            tick(1);
            if (prev == 3'd0 && ifa.state_o == 3'd1) trans++;
            else if (prev != ifa.state_o) other++;
            prev = ifa.state_o;
        end
        n_cmp++; if (trans !== 1 || other !== 0) begin n_bad++; $display("FAIL bounce_pulses: got %0d advances %0d other changes, want 1 and 0", trans, other); end
        n_cmp++; if (ifa.state_o !== 3'd1) begin n_bad++; $display("FAIL bounce_state: got %0d want 1", ifa.state_o); end
        press(1);
    endtask

    task automatic test_full_sequence;
        bit          found = 0;
        logic [34:0] exp;
        sw_data = 16'h0005; press(0);
        sw_data = 16'hFFFD; press(0);
        @(negedge CLK);
        n_cmp++; if (ifa.alu_portb !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL seq_portb: got %h want FFFFFFFD", ifa.alu_portb); end
        sw_data = 16'hABC2;
        @(negedge CLK);
        n_cmp++; if (ifa.disp_value !== 32'h00000002) begin n_bad++; $display("FAIL seq_op_disp: got %h want 00000002", ifa.disp_value); end
        exp_q.push_back({32'h00000002, 3'b000});
        key_n[0] = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (ifa.state_o == 3'd3) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL seq_exec_timeout: state got %0d want 3", ifa.state_o);
        end else begin
            n_cmp++; if ({ifa.result_valid, ifa.disp_value} !== {1'b0, 32'h2}) begin n_bad++; $display("FAIL seq_exec: got rv=%b disp=%h want 0 00000002", ifa.result_valid, ifa.disp_value); end
            @(negedge CLK);
            n_cmp++; if ({ifa.state_o, ifa.result_valid} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL seq_latency: got state=%0d rv=%b want 4 1", ifa.state_o, ifa.result_valid); end
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            n_cmp++; if ({ifa.result, ifa.flags} !== exp) begin n_bad++; $display("FAIL seq_result: got %h/%b want %h/%b", ifa.result, ifa.flags, exp[34:3], exp[2:0]); end
            n_cmp++; if ({ifa.alu_op, ifa.disp_value} !== {4'h2, 32'h2}) begin n_bad++; $display("FAIL seq_op_show: got op=%h disp=%h want 2 00000002", ifa.alu_op, ifa.disp_value); end
        end
        key_n[0] = 1'b1;
        tick(8);
    endtask

    task automatic test_reset_in_show;
        n_cmp++; if (ifa.state_o !== 3'd4) begin n_bad++; $display("FAIL pre_reset_state: got %0d want 4", ifa.state_o); end
        nRST = 1'b0;
        tick(1);
        nRST = 1'b1;
        @(negedge CLK);
        n_cmp++; if (ifa.state_o !== 3'd0) begin n_bad++; $display("FAIL show_reset_state: got %0d want 0", ifa.state_o); end
        n_cmp++; if ({ifa.alu_porta, ifa.alu_portb, ifa.alu_op, ifa.result, ifa.flags, ifa.result_valid} !== 104'd0) begin
            n_bad++; $display("FAIL show_reset_outputs: got %h %h %h %h %b %b want all 0", ifa.alu_porta, ifa.alu_portb, ifa.alu_op, ifa.result, ifa.flags, ifa.result_valid);
        end
    endtask

    task automatic test_clear_exec;
        bit saw_exec = 0;
        bit saw_rv = 0;
        sw_data = 16'h0001; press(0);
        sw_data = 16'h0002; press(0);
        sw_data = 16'h0003;
        key_n[0] = 1'b0;
        tick(2);
        key_n[1] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if (ifb.state_o == 3'd3) saw_exec = 1;
            if (ifb.result_valid) saw_rv = 1;
        end
        n_cmp++; if (saw_exec !== 1'b1) begin n_bad++; $display("FAIL clr_exec_reached: got %b want 1", saw_exec); end
        n_cmp++; if (saw_rv !== 1'b0) begin n_bad++; $display("FAIL clr_exec_capture: result_valid seen %b want 0", saw_rv); end
        n_cmp++; if ({ifb.state_o, ifb.result, ifb.result_valid} !== 36'd0) begin n_bad++; $display("FAIL clr_exec_state: got %0d %h %b want 0 0 0", ifb.state_o, ifb.result, ifb.result_valid); end
        key_n = 2'b11;
        tick(8);
    endtask

    task automatic test_enter_clear;
        sw_data = 16'h1234; press(0);
        @(negedge CLK);
        n_cmp++; if (ifa.alu_porta !== 32'h00001234) begin n_bad++; $display("FAIL ec_porta_load: got %h want 00001234", ifa.alu_porta); end
        key_n = 2'b00;
        tick(8);
        @(negedge CLK);
        n_cmp++; if ({ifa.state_o, ifa.alu_porta, ifa.alu_portb} !== 67'd0) begin n_bad++; $display("FAIL ec_clear_wins: got %0d %h %h want 0 0 0", ifa.state_o, ifa.alu_porta, ifa.alu_portb); end
        n_cmp++; if (ifb.state_o !== 3'd0) begin n_bad++; $display("FAIL ec_clear_wins_b: got %0d want 0", ifb.state_o); end
        key_n = 2'b11;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_bounce();
        test_full_sequence();
        test_reset_in_show();
        test_clear_exec();
        test_enter_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
